// File: rtl/if_pkg.sv
// Shared fetch-side types: the entry carried from IF to ID and the ARM no-op
// that decode sees while the queue is empty.
package if_pkg;

  localparam logic [31:0] NOP_INSTR = 32'hE1A00000;

  typedef struct packed {
    logic [31:0] instruction;
    logic [31:0] pc;
    logic [31:0] pc_plus_4;
  } fetch_entry_t;

endpackage

// File: rtl/if_id_queue.sv
// Small FIFO between fetch and decode: one 96-bit entry per slot, flushed
// wholesale on a taken branch, presenting a NOP to decode when empty.
module if_id_queue #(
  parameter int          DEPTH     = 2,
  parameter logic [31:0] NOP_INSTR = if_pkg::NOP_INSTR
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic                         flush,
  input  logic                         in_valid,
  output logic                         in_ready,
  input  logic [31:0]                  in_instruction,
  input  logic [31:0]                  in_pc,
  input  logic [31:0]                  in_pc_plus_4,
  output logic                         out_valid,
  input  logic                         out_ready,
  output logic [31:0]                  out_instruction,
  output logic [31:0]                  out_pc,
  output logic [31:0]                  out_pc_plus_4,
  output logic [$clog2(DEPTH+1)-1:0]   occupancy
);

  import if_pkg::fetch_entry_t;

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = $clog2(DEPTH+1);

  fetch_entry_t     mem [DEPTH];
  fetch_entry_t     wr_entry;
  fetch_entry_t     head;
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic [CNT_W-1:0] count;
  logic             push;
  logic             pop;

  // Handshake flags come from the registered count only, so out_ready never
  // reaches in_ready combinationally.
  assign in_ready  = (count != CNT_W'(DEPTH));
  assign out_valid = (count != '0);
  assign push      = in_valid & in_ready;
  assign pop       = out_valid & out_ready;
  assign occupancy = count;

  assign wr_entry = '{instruction: in_instruction, pc: in_pc, pc_plus_4: in_pc_plus_4};
  assign head     = mem[rd_ptr];

  assign out_instruction = out_valid ? head.instruction : NOP_INSTR;
  assign out_pc          = out_valid ? head.pc          : 32'd0;
  assign out_pc_plus_4   = out_valid ? head.pc_plus_4   : 32'd0;

  // Control state: reset beats flush, flush discards any same-cycle push/pop.
  always_ff @(posedge clk) begin
    if (!reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else if (flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + PTR_W'(1);
      if (pop)  rd_ptr <= rd_ptr + PTR_W'(1);
      count <= count + CNT_W'(push) - CNT_W'(pop);
    end
  end

  // Storage is never cleared; count alone decides what is visible.
  always_ff @(posedge clk) begin
    if (reset && !flush && push) mem[wr_ptr] <= wr_entry;
  end

endmodule

// File: tb/tb_if_id_queue.sv
// Random and directed traffic through if_id_queue, checked against a queue model.
module tb_if_id_queue;
  import if_pkg::*;

  localparam int DEPTH = 2;
  localparam int OCC_W = $clog2(DEPTH+1);

  logic              clk = 1'b0;
  logic              reset = 1'b0;
  logic              flush = 1'b0;
  logic              in_valid = 1'b1;
  logic              in_ready;
  logic [31:0]       in_instruction = 32'd0;
  logic [31:0]       in_pc = 32'd0;
  logic [31:0]       in_pc_plus_4 = 32'd4;
  logic              out_valid;
  logic              out_ready = 1'b0;
  logic [31:0]       out_instruction;
  logic [31:0]       out_pc;
  logic [31:0]       out_pc_plus_4;
  logic [OCC_W-1:0]  occupancy;

  int checks = 0;
  int failures = 0;
  fetch_entry_t exp_q[$];

  always #5 clk = ~clk;

  if_id_queue #(.DEPTH(DEPTH)) dut (
    .clk(clk), .reset(reset), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_instruction(in_instruction), .in_pc(in_pc), .in_pc_plus_4(in_pc_plus_4),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_instruction(out_instruction), .out_pc(out_pc), .out_pc_plus_4(out_pc_plus_4),
    .occupancy(occupancy)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h expected=%h at %0t", name, act, exp, $time);
    end
  endtask

  // Monitor: 2 time units after each falling edge (inputs settled), compare the
  // DUT against the model and consume the head if ID takes it at the next edge.
  initial begin
    forever begin
      @(negedge clk);
      #2;
      check("out_valid", 32'(out_valid), 32'(exp_q.size() != 0));
      check("in_ready", 32'(in_ready), 32'(exp_q.size() < DEPTH));
      check("occupancy", 32'(occupancy), 32'(exp_q.size()));
      if (exp_q.size() == 0) begin
        check("nop_instr", out_instruction, 32'hE1A00000);
        check("nop_pc", out_pc, 32'd0);
        check("nop_pc4", out_pc_plus_4, 32'd0);
      end else begin
        check("head_instr", out_instruction, exp_q[0].instruction);
        check("head_pc", out_pc, exp_q[0].pc);
        check("head_pc4", out_pc_plus_4, exp_q[0].pc_plus_4);
        if (out_ready && reset && !flush) void'(exp_q.pop_front());
      end
    end
  end

  // One cycle of stimulus; the expected entry is queued after the monitor has looked.
  task automatic drive(input bit rst_n, input bit fl, input bit iv, input bit ordy,
                       input logic [31:0] pc);
    bit accept;
    fetch_entry_t e;
    @(negedge clk);
    reset          = rst_n;
    flush          = fl;
    in_valid       = iv;
    out_ready      = ordy;
    in_instruction = $urandom;
    in_pc          = pc;
    in_pc_plus_4   = pc + 32'd4;
    e.instruction  = in_instruction;
    e.pc           = pc;
    e.pc_plus_4    = pc + 32'd4;
    accept = rst_n && !fl && iv && (exp_q.size() < DEPTH);
    #4;
    if (!rst_n || fl) exp_q.delete();
    else if (accept) exp_q.push_back(e);
  endtask

  initial begin
    // Reset held two cycles with in_valid asserted
    drive(1'b0, 1'b0, 1'b1, 1'b0, 32'h100);
    drive(1'b1, 1'b0, 1'b0, 1'b0, 32'h0);

    // Fill, attempt a third push, then drain
    drive(1'b1, 1'b0, 1'b1, 1'b0, 32'h00);
    drive(1'b1, 1'b0, 1'b1, 1'b0, 32'h04);
    drive(1'b1, 1'b0, 1'b1, 1'b0, 32'h08);
    drive(1'b1, 1'b0, 1'b0, 1'b1, 32'h0);
    drive(1'b1, 1'b0, 1'b0, 1'b1, 32'h0);
    drive(1'b1, 1'b0, 1'b0, 1'b1, 32'h0);

    // Streaming pc 0x00..0x24
    for (int i = 0; i < 10; i++) drive(1'b1, 1'b0, 1'b1, 1'b1, 32'(i * 4));
    drive(1'b1, 1'b0, 1'b0, 1'b1, 32'h0);

    // Full with simultaneous pop
    drive(1'b1, 1'b0, 1'b1, 1'b0, 32'h20);
    drive(1'b1, 1'b0, 1'b1, 1'b0, 32'h24);
    drive(1'b1, 1'b0, 1'b1, 1'b1, 32'h28);
    drive(1'b1, 1'b0, 1'b0, 1'b1, 32'h0);
    drive(1'b1, 1'b0, 1'b0, 1'b1, 32'h0);

    // Flush with a concurrent push, then the branch target
    drive(1'b1, 1'b0, 1'b1, 1'b0, 32'h08);
    drive(1'b1, 1'b0, 1'b1, 1'b0, 32'h0C);
    drive(1'b1, 1'b1, 1'b1, 1'b1, 32'h10);
    drive(1'b1, 1'b0, 1'b1, 1'b0, 32'h40);
    drive(1'b1, 1'b0, 1'b0, 1'b1, 32'h0);
    drive(1'b1, 1'b0, 1'b0, 1'b0, 32'h0);

    // Wrap: seven push/pop pairs
    for (int i = 0; i < 7; i++) begin
      drive(1'b1, 1'b0, 1'b1, 1'b0, 32'h200 + 32'(i * 4));
      drive(1'b1, 1'b0, 1'b0, 1'b1, 32'h0);
    end

    // Random traffic with occasional flush and reset
    for (int i = 0; i < 600; i++) begin
      drive(($urandom_range(0, 39) != 0), ($urandom_range(0, 15) == 0),
            ($urandom_range(0, 3) != 0), ($urandom_range(0, 2) != 0),
            {$urandom_range(0, 32'h3FFF_FFFF), 2'b00});
    end

    drive(1'b1, 1'b0, 1'b0, 1'b1, 32'h0);
    @(negedge clk);
    #3;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
